// File: rtl/ramarb_pkg.sv
// Shared types and constants for the three-master RAM data-port arbiter.
package ramarb_pkg;

  localparam int NUM_MASTERS = 3;
  localparam int ADDR_W      = 26;
  localparam int DATA_W      = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef logic [1:0] midx_t;

  localparam midx_t M_CPU = 2'd0;
  localparam midx_t M_DMA = 2'd1;
  localparam midx_t M_DBG = 2'd2;

  function automatic midx_t next_idx(input midx_t i);
    return (i == M_DBG) ? M_CPU : midx_t'(i + 2'd1);
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input midx_t i);
    return 3'b001 << i;
  endfunction

endpackage

// File: rtl/ramarb_rr_pick3.sv
// Combinational round-robin pick among three requesters.
module rr_pick3
  import ramarb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  midx_t                  ptr,
  output midx_t                  idx,
  output logic                   valid
);

  midx_t c1;
  midx_t c2;

  // Search order starts just after the last winner.
  always_comb begin
    c1    = next_idx(ptr);
    c2    = next_idx(c1);
    valid = |req;
    if (req[c1])
      idx = c1;
    else if (req[c2])
      idx = c2;
    else
      idx = ptr;
  end

endmodule

// File: rtl/ramarb.sv
// Round-robin arbiter sharing the RAM controller data port among three
// masters, with per-master lock and a transaction watchdog.
module ramarb
  import ramarb_pkg::*;
#(
  parameter int WDOG_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_stb,
  input  logic [NUM_MASTERS-1:0] m_we,
  input  logic [NUM_MASTERS-1:0] m_lock,
  input  logic [ADDR_W-1:0]      m0_addr,
  input  logic [ADDR_W-1:0]      m1_addr,
  input  logic [ADDR_W-1:0]      m2_addr,
  input  logic [DATA_W-1:0]      m0_din,
  input  logic [DATA_W-1:0]      m1_din,
  input  logic [DATA_W-1:0]      m2_din,
  output logic [DATA_W-1:0]      m_dout,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [NUM_MASTERS-1:0] m_timeout,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_dout,
  input  logic [DATA_W-1:0]      s_din,
  input  logic                   s_ack,
  input  logic                   s_timeout
);

  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WDOG_CYCLES - 1);

  state_t        state;
  midx_t         grant;
  midx_t         rr_ptr;
  logic [WW-1:0] wdog;
  midx_t         pick;
  logic          pick_ok;
  logic          wd_exp;
  logic          sel_we;

  rr_pick3 u_pick (
    .req   (m_stb),
    .ptr   (rr_ptr),
    .idx   (pick),
    .valid (pick_ok)
  );

  assign wd_exp = (wdog == WLAST);
  assign m_dout = s_din;

  always_comb begin
    s_stb  = (state == BUSY) || (state == DRAIN);
    sel_we = 1'b0;
    s_addr = '0;
    s_dout = '0;
    case (grant)
      M_CPU: begin
        sel_we = m_we[0];
        s_addr = m0_addr;
        s_dout = m0_din;
      end
      M_DMA: begin
        sel_we = m_we[1];
        s_addr = m1_addr;
        s_dout = m1_din;
      end
      M_DBG: begin
        sel_we = m_we[2];
        s_addr = m2_addr;
        s_dout = m2_din;
      end
      default: ;
    endcase
    s_we = s_stb & sel_we;
  end

  // Slave ack beats a coincident watchdog expiry.
  always_comb begin
    m_ack     = '0;
    m_timeout = '0;
    if (state == BUSY) begin
      if (s_ack)
        m_ack = onehot(grant);
      else if (s_timeout || wd_exp)
        m_timeout = onehot(grant);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= M_CPU;
      rr_ptr <= M_DBG;
      wdog   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            grant <= pick;
            wdog  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack || s_timeout) begin
            rr_ptr <= grant;
            state  <= m_lock[grant] ? HOLD : IDLE;
          end else if (wd_exp) begin
            state <= DRAIN;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        // Slave cannot be aborted; swallow its late response.
        DRAIN: begin
          if (s_ack || s_timeout) begin
            rr_ptr <= grant;
            state  <= IDLE;
          end
        end
        HOLD: begin
          if (m_stb[grant]) begin
            wdog  <= '0;
            state <= BUSY;
          end else if (!m_lock[grant]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramarb.sv
// Directed self-checking bench for ramarb (watchdog shortened to 8 cycles).
module tb_ramarb;
  import ramarb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        m_stb, m_we, m_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr;
  logic [DATA_W-1:0] m0_din, m1_din, m2_din;
  logic [DATA_W-1:0] m_dout;
  logic [2:0]        m_ack, m_timeout;
  logic              s_stb, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_dout, s_din;
  logic              s_ack, s_timeout;

  int checks = 0;
  int errors = 0;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_dout;

  always #5 clk = ~clk;

  ramarb #(.WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_stb(m_stb), .m_we(m_we), .m_lock(m_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m2_addr(m2_addr),
    .m0_din(m0_din), .m1_din(m1_din), .m2_din(m2_din),
    .m_dout(m_dout), .m_ack(m_ack), .m_timeout(m_timeout),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dout(s_dout),
    .s_din(s_din), .s_ack(s_ack), .s_timeout(s_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for s_stb, respond in BUSY cycle lat, sample master-side result.
  task automatic serve(input int lat, input bit slv_to,
                       output logic [2:0] ack, output logic [2:0] tmo);
    int n = 0;
    ack = '0;
    tmo = '0;
    while (!s_stb && n < 20) begin
      tick();
      n++;
    end
    if (!s_stb) begin
      chk("serve_wait", {63'd0, s_stb}, 64'd1);
      return;
    end
    for (int i = 1; i < lat; i++) tick();
    if (slv_to) s_timeout = 1'b1;
    else s_ack = 1'b1;
    #1;
    ack      = m_ack;
    tmo      = m_timeout;
    cap_we   = s_we;
    cap_addr = s_addr;
    cap_dout = s_dout;
    tick();
    s_ack     = 1'b0;
    s_timeout = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [2:0] a, t;
    logic [2:0] order [6];
    int bad;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;

    rst = 1'b1;
    m_stb = '0; m_we = '0; m_lock = '0;
    m0_addr = '0; m1_addr = '0; m2_addr = '0;
    m0_din = '0; m1_din = '0; m2_din = '0;
    s_din = '0; s_ack = 1'b0; s_timeout = 1'b0;

    tick();
    chk("rst_s_stb", {63'd0, s_stb}, 64'd0);
    chk("rst_s_we", {63'd0, s_we}, 64'd0);
    chk("rst_m_ack", {61'd0, m_ack}, 64'd0);
    chk("rst_m_tmo", {61'd0, m_timeout}, 64'd0);
    rst = 1'b0;

    // single m1 read, slave acks in BUSY cycle 4
    m_stb = 3'b010;
    m1_addr = 26'h0000100;
    #1;
    chk("single_idle", {63'd0, s_stb}, 64'd0);
    tick();
    chk("single_stb", {63'd0, s_stb}, 64'd1);
    chk("single_addr", {38'd0, s_addr}, 64'h100);
    tick();
    tick();
    tick();
    s_ack = 1'b1;
    s_din = 64'h1122334455667788;
    #1;
    chk("single_ack", {61'd0, m_ack}, 64'b010);
    chk("single_dout", m_dout, 64'h1122334455667788);
    tick();
    s_ack = 1'b0;
    m_stb = '0;
    #1;
    chk("single_ack_1cyc", {61'd0, m_ack}, 64'd0);
    chk("single_back_idle", {63'd0, s_stb}, 64'd0);

    // fairness from reset
    do_reset();
    m_stb = 3'b111;
    for (int i = 0; i < 6; i++) begin
      serve(2, 1'b0, a, t);
      chk($sformatf("fair_%0d", i), {61'd0, a}, {61'd0, order[i]});
    end

    // m0 locked read then write to 0x200 while m1/m2 wait
    m_lock = 3'b001;
    m0_addr = 26'h0000200;
    m_we = 3'b000;
    serve(2, 1'b0, a, t);
    chk("lock_rd_ack", {61'd0, a}, 64'b001);
    chk("lock_rd_addr", {38'd0, cap_addr}, 64'h200);
    m_stb = 3'b110;
    m_we = 3'b001;
    m0_din = 64'hDEADBEEFCAFEF00D;
    #1;
    chk("lock_hold0", {63'd0, s_stb}, 64'd0);
    tick();
    chk("lock_hold1", {63'd0, s_stb}, 64'd0);
    m_stb = 3'b111;
    serve(2, 1'b0, a, t);
    chk("lock_wr_ack", {61'd0, a}, 64'b001);
    chk("lock_wr_we", {63'd0, cap_we}, 64'd1);
    chk("lock_wr_data", cap_dout, 64'hDEADBEEFCAFEF00D);
    m_lock = 3'b000;
    m_stb = 3'b110;
    m_we = 3'b000;
    serve(2, 1'b0, a, t);
    chk("lock_release_m1", {61'd0, a}, 64'b010);
    m_stb = 3'b100;
    serve(2, 1'b0, a, t);
    chk("lock_then_m2", {61'd0, a}, 64'b100);
    m_stb = '0;

    // watchdog: slave silent, m0 times out on BUSY cycle 8
    m_stb = 3'b011;
    tick();
    bad = 0;
    for (int c = 1; c < 8; c++) begin
      #1;
      if (m_timeout != 3'b000) bad++;
      tick();
    end
    #1;
    chk("wdog_quiet", 64'(bad), 64'd0);
    chk("wdog_tmo", {61'd0, m_timeout}, 64'b001);
    chk("wdog_no_ack", {61'd0, m_ack}, 64'd0);
    tick();
    m_stb = 3'b010;
    bad = 0;
    for (int c = 9; c < 20; c++) begin
      #1;
      if (!s_stb || m_timeout != 3'b000) bad++;
      tick();
    end
    chk("drain_hold", 64'(bad), 64'd0);
    m_stb = 3'b011;
    s_ack = 1'b1;
    #1;
    chk("drain_ack_hidden", {61'd0, m_ack}, 64'd0);
    chk("drain_tmo_hidden", {61'd0, m_timeout}, 64'd0);
    tick();
    s_ack = 1'b0;
    #1;
    chk("drain_to_idle", {63'd0, s_stb}, 64'd0);
    serve(1, 1'b0, a, t);
    chk("wdog_next_m1", {61'd0, a}, 64'b010);
    m_stb = '0;

    // m2 write, slave reports timeout
    m_stb = 3'b100;
    m_we = 3'b100;
    m2_addr = 26'h3C00000;
    m2_din = 64'h0123456789ABCDEF;
    serve(3, 1'b1, a, t);
    chk("stmo_tmo", {61'd0, t}, 64'b100);
    chk("stmo_ack", {61'd0, a}, 64'd0);
    chk("stmo_addr", {38'd0, cap_addr}, 64'h3C00000);
    chk("stmo_we", {63'd0, cap_we}, 64'd1);
    m_stb = '0;
    m_we = '0;
    #1;
    chk("stmo_idle", {63'd0, s_stb}, 64'd0);

    // ack coinciding with watchdog expiry
    m_stb = 3'b001;
    serve(8, 1'b0, a, t);
    chk("race_ack", {61'd0, a}, 64'b001);
    chk("race_tmo", {61'd0, t}, 64'd0);
    m_stb = '0;
    #1;
    chk("race_idle", {63'd0, s_stb}, 64'd0);

    // reset in BUSY cycle 2 of an m1 transaction
    m_stb = 3'b010;
    tick();
    tick();
    rst = 1'b1;
    s_ack = 1'b1;
    #1;
    chk("mid_rst_stb", {63'd0, s_stb}, 64'd0);
    chk("mid_rst_ack", {61'd0, m_ack}, 64'd0);
    chk("mid_rst_tmo", {61'd0, m_timeout}, 64'd0);
    tick();
    rst = 1'b0;
    s_ack = 1'b0;
    m_stb = 3'b111;
    serve(1, 1'b0, a, t);
    chk("post_rst_m0", {61'd0, a}, 64'b001);
    m_stb = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
